crc32_frame_checker: RTL and testbench

//  Receive-side companion to the byte-wise CRC-32 generator. It accepts a byte stream

---
 rtl/crc32_frame_checker_if.sv | 11 +
 rtl/crc32_frame_checker.sv | 126 ++++++++++++
 tb/tb_crc32_frame_checker.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/crc32_frame_checker_if.sv
// Byte-stream handshake between a byte source and the CRC-32 frame checker.
// The source uses the master modport and the checker uses the slave modport.
interface crc32_frame_checker_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32 checker: a 4-byte delay line keeps the trailing CRC bytes out of
// the running CRC, and a result is reported on a one-cycle done pulse at frame end.
module crc32_frame_checker #(
    parameter logic [31:0] POLY    = 32'hEDB88320,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
    parameter int          LEN_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    crc32_frame_checker_if.slave s,
    output logic                 done,
    output logic                 crc_ok,
    output logic                 short_err,
    output logic [31:0]          crc_calc,
    output logic [31:0]          crc_recv,
    output logic [LEN_W-1:0]     frame_len
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       crc_q, crc_d;
    logic [3:0][7:0]   sr_q, sr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              crc_ok_q, crc_ok_d;
    logic              short_err_q, short_err_d;
    logic [31:0]       crc_calc_q, crc_calc_d;
    logic [31:0]       crc_recv_q, crc_recv_d;
    logic [LEN_W-1:0]  frame_len_q, frame_len_d;

    logic              fire;
    logic [LEN_W-1:0]  cnt_inc;
    logic [31:0]       crc_fold;

    function automatic logic [31:0] crc_update(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] r;
        r = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign s.s_ready = (state_q != DONE);
    assign fire      = s.s_valid && (state_q != DONE);
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);
    // The oldest delay-line byte is payload only once four newer bytes sit behind it.
    assign crc_fold  = (cnt_q >= LEN_W'(4)) ? crc_update(crc_q, sr_q[3]) : crc_q;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        crc_ok_d    = crc_ok_q;
        short_err_d = short_err_q;
        crc_calc_d  = crc_calc_q;
        crc_recv_d  = crc_recv_q;
        frame_len_d = frame_len_q;

        case (state_q)
            IDLE, RUN: begin
                if (fire) begin
                    sr_d    = {sr_q[2:0], s.s_data};
                    cnt_d   = cnt_inc;
                    crc_d   = crc_fold;
                    state_d = RUN;
                    if (s.s_last) begin
                        state_d     = DONE;
                        frame_len_d = cnt_inc;
                        if (cnt_q >= LEN_W'(3)) begin
                            crc_recv_d  = {s.s_data, sr_q[0], sr_q[1], sr_q[2]};
                            crc_calc_d  = crc_fold ^ XOR_OUT;
                            crc_ok_d    = ((crc_fold ^ XOR_OUT) == {s.s_data, sr_q[0], sr_q[1], sr_q[2]});
                            short_err_d = 1'b0;
                        end else begin
                            crc_recv_d  = 32'd0;
                            crc_calc_d  = 32'd0;
                            crc_ok_d    = 1'b0;
                            short_err_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                crc_d   = INIT;
                sr_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            sr_q        <= '0;
            cnt_q       <= '0;
            crc_ok_q    <= 1'b0;
            short_err_q <= 1'b0;
            crc_calc_q  <= 32'd0;
            crc_recv_q  <= 32'd0;
            frame_len_q <= '0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            crc_ok_q    <= crc_ok_d;
            short_err_q <= short_err_d;
            crc_calc_q  <= crc_calc_d;
            crc_recv_q  <= crc_recv_d;
            frame_len_q <= frame_len_d;
        end
    end

    assign done      = (state_q == DONE);
    assign crc_ok    = crc_ok_q;
    assign short_err = short_err_q;
    assign crc_calc  = crc_calc_q;
    assign crc_recv  = crc_recv_q;
    assign frame_len = frame_len_q;

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Directed bench for crc32_frame_checker: a 16-bit-length instance and a 4-bit-length
// instance receive the same byte stream so length saturation can be observed.
module tb_crc32_frame_checker;

    logic clk;
    logic reset;

    crc32_frame_checker_if busA ();
    crc32_frame_checker_if busB ();

    logic        doneA, crcOkA, shortErrA;
    logic [31:0] crcCalcA, crcRecvA;
    logic [15:0] frameLenA;
    logic        doneB, crcOkB, shortErrB;
    logic [31:0] crcCalcB, crcRecvB;
    logic [3:0]  frameLenB;

    int checks   = 0;
    int failures = 0;

    logic [7:0] frame1 [0:12] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                                  8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

    crc32_frame_checker #(.LEN_W(16)) dut (
        .clk(clk), .reset(reset), .s(busA.slave),
        .done(doneA), .crc_ok(crcOkA), .short_err(shortErrA),
        .crc_calc(crcCalcA), .crc_recv(crcRecvA), .frame_len(frameLenA)
    );

    crc32_frame_checker #(.LEN_W(4)) dutSmall (
        .clk(clk), .reset(reset), .s(busB.slave),
        .done(doneB), .crc_ok(crcOkB), .short_err(shortErrB),
        .crc_calc(crcCalcB), .crc_recv(crcRecvB), .frame_len(frameLenB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial reference CRC-32 over a 16-byte payload, used only for the long frame.
    function automatic logic [31:0] crcRef(input logic [7:0] m [0:15]);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        for (int i = 0; i < 16; i++) begin
            r = r ^ {24'd0, m[i]};
            for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return ~r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Entered and left at a falling edge; the byte transfers on the rising edge between.
    task automatic applyStimulus(input logic [7:0] data, input logic last, input int gap);
        int waitCycles;
        repeat (gap) @(negedge clk);
        waitCycles = 0;
        while (busA.s_ready !== 1'b1 && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        if (waitCycles >= 10) checkOutput("ready_timeout", {63'd0, busA.s_ready}, 64'd1);
        busA.s_valid = 1'b1; busA.s_data = data; busA.s_last = last;
        busB.s_valid = 1'b1; busB.s_data = data; busB.s_last = last;
        @(negedge clk);
        busA.s_valid = 1'b0; busA.s_last = 1'b0;
        busB.s_valid = 1'b0; busB.s_last = 1'b0;
    endtask

    task automatic sendFrame1(input logic [7:0] lastByte, input int maxGap);
        for (int i = 0; i < 13; i++) begin
            applyStimulus((i == 12) ? lastByte : frame1[i], (i == 12), (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
        end
    endtask

    task automatic checkResult(input string tag, input logic ok, input logic shortE,
                               input logic [31:0] calc, input logic [31:0] recv, input logic [15:0] len);
        checkOutput({tag, "_done"},  {63'd0, doneA}, 64'd1);
        checkOutput({tag, "_ready"}, {63'd0, busA.s_ready}, 64'd0);
        checkOutput({tag, "_ok"},    {63'd0, crcOkA}, {63'd0, ok});
        checkOutput({tag, "_short"}, {63'd0, shortErrA}, {63'd0, shortE});
        checkOutput({tag, "_calc"},  {32'd0, crcCalcA}, {32'd0, calc});
        checkOutput({tag, "_recv"},  {32'd0, crcRecvA}, {32'd0, recv});
        checkOutput({tag, "_len"},   {48'd0, frameLenA}, {48'd0, len});
    endtask

    initial begin
        logic [7:0]  pay [0:15];
        logic [31:0] ref6;

        reset = 1'b1;
        busA.s_valid = 1'b0; busA.s_data = 8'h00; busA.s_last = 1'b0;
        busB.s_valid = 1'b0; busB.s_data = 8'h00; busB.s_last = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", {63'd0, busA.s_ready}, 64'd1);
        checkOutput("rst_done",  {63'd0, doneA}, 64'd0);
        checkOutput("rst_outs",  {crcCalcA, crcRecvA}, 64'd0);
        checkOutput("rst_flags", {46'd0, crcOkA, shortErrA, frameLenA}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Standard check string with correct trailing CRC.
        sendFrame1(8'hCB, 0);
        checkResult("t1", 1'b1, 1'b0, 32'hCBF43926, 32'hCBF43926, 16'd13);
        @(negedge clk);
        checkOutput("t1_done_pulse", {63'd0, doneA}, 64'd0);
        checkOutput("t1_ready_back", {63'd0, busA.s_ready}, 64'd1);
        checkOutput("t1_hold_calc",  {32'd0, crcCalcA}, 64'hCBF43926);

        sendFrame1(8'hCA, 0);
        checkResult("t2", 1'b0, 1'b0, 32'hCBF43926, 32'hCAF43926, 16'd13);

        applyStimulus(8'h00, 1'b0, 0);
        applyStimulus(8'h00, 1'b0, 0);
        applyStimulus(8'h00, 1'b0, 0);
        applyStimulus(8'h00, 1'b1, 0);
        checkResult("t3_empty", 1'b1, 1'b0, 32'h0, 32'h0, 16'd4);

        applyStimulus(8'h01, 1'b0, 0);
        applyStimulus(8'h02, 1'b0, 0);
        applyStimulus(8'h03, 1'b1, 0);
        checkResult("t3_short", 1'b0, 1'b1, 32'h0, 32'h0, 16'd3);

        applyStimulus(8'h5A, 1'b1, 2);
        checkResult("t3_one", 1'b0, 1'b1, 32'h0, 32'h0, 16'd1);

        // Random gaps, then an identical frame presented right after the DONE bubble.
        sendFrame1(8'hCB, 5);
        checkResult("t4_a", 1'b1, 1'b0, 32'hCBF43926, 32'hCBF43926, 16'd13);
        sendFrame1(8'hCB, 0);
        checkResult("t4_b", 1'b1, 1'b0, 32'hCBF43926, 32'hCBF43926, 16'd13);

        // Abort a frame with reset after six bytes.
        @(negedge clk);
        for (int i = 0; i < 6; i++) applyStimulus(frame1[i], 1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("t5_rst_done", {63'd0, doneA}, 64'd0);
        checkOutput("t5_rst_outs", {crcCalcA, crcRecvA}, 64'd0);
        checkOutput("t5_rst_len",  {48'd0, frameLenA}, 64'd0);
        @(negedge clk);
        checkOutput("t5_no_done",  {63'd0, doneA}, 64'd0);
        sendFrame1(8'hCB, 0);
        checkResult("t5", 1'b1, 1'b0, 32'hCBF43926, 32'hCBF43926, 16'd13);

        // 20-byte frame: the 4-bit length counter saturates, the CRC does not care.
        for (int i = 0; i < 16; i++) pay[i] = 8'(8'h30 + i);
        ref6 = crcRef(pay);
        for (int i = 0; i < 16; i++) applyStimulus(pay[i], 1'b0, 0);
        applyStimulus(ref6[7:0],   1'b0, 0);
        applyStimulus(ref6[15:8],  1'b0, 0);
        applyStimulus(ref6[23:16], 1'b0, 0);
        applyStimulus(ref6[31:24], 1'b1, 0);
        checkResult("t6_wide", 1'b1, 1'b0, ref6, ref6, 16'd20);
        checkOutput("t6_small_done", {63'd0, doneB}, 64'd1);
        checkOutput("t6_small_ok",   {63'd0, crcOkB}, 64'd1);
        checkOutput("t6_small_calc", {32'd0, crcCalcB}, {32'd0, ref6});
        checkOutput("t6_small_len",  {60'd0, frameLenB}, 64'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
